ball_motion_ctrl: RTL and testbench
===================================

# ball_motion_ctrl

Frame-rate motion controller for the bouncing-ball datapath. Sits between the VGA timing generator and the ball renderer. It gates the per-frame vertical-reset pulse that makes the renderer step the ball one pixel per axis, and sequences idle/serve/run/pause. It also tracks the ball's horizontal position and drives the renderer's horizontal-direction input, so the ball bounces off the left and right screen edges.

## Interface

Parameters:
- `H_VISIBLE` = 640: visible pixels per line.
- `BALL_SIZE` = 10: ball edge length in pixels.
- `START_X` = 316: initial left-edge column, 1-based; must match the renderer's start position.
- `FRAME_DIV` = 1: forward one step per FRAME_DIV frames; legal range 1..15.
- `SERVE_FRAMES` = 60: frames spent in SERVE before motion starts; legal range 1..255.

Ports (reset is asynchronous, active-low; all other logic is synchronous to `i_Clk`):
- `i_Clk`  in  1  pixel clock.
- `i_Rst_n`  in  1  asynchronous active-low reset.
- `i_VReset`  in  1  one-cycle frame-start pulse from VGA timing.
- `i_Start`  in  1  debounced start level; acted on at its rising edge.
- `i_Pause`  in  1  debounced pause level; acted on at its rising edge.
- `o_VReset`  out  1  gated frame pulse to the renderer.
- `o_XDir`  out  1  horizontal direction: 1 = moving right (+1 px/step), 0 = moving left.
- `o_BallX`  out  10  tracked left-edge column, range 1..H_VISIBLE-BALL_SIZE+1.
- `o_Running`  out  1  high in RUN.
- `o_Bounce`  out  1  one-cycle pulse when the direction flips.

## Operation

- Edge detect: register `i_Start` and `i_Pause`. The registers reset to 1, so a level held through reset produces no edge.
- States are IDLE, SERVE, RUN and PAUSED. Reset enters IDLE.
- IDLE: no pulses are forwarded. A start edge sets the serve counter to 0 and moves to SERVE.
- SERVE: each `i_VReset` increments the serve counter (8 bits). On the pulse where the count reaches SERVE_FRAMES-1, move to RUN and clear the divider. No pulse is forwarded in SERVE.
- RUN: each `i_VReset` advances the divider (4 bits, 0..FRAME_DIV-1).
  - When the divider equals FRAME_DIV-1, clear it and forward a step. Otherwise increment it.
  - A pause edge moves to PAUSED.
- PAUSED: no pulses are forwarded and the divider holds its value. A pause edge returns to RUN. A start edge is ignored.
- A start edge in SERVE, RUN or PAUSED is ignored.
- Step (forwarded pulse):
  - `o_VReset`=1 for exactly one cycle.
  - In the same cycle, `o_BallX` is updated +1 if `o_XDir`=1, else -1.
- Bounce, evaluated the cycle after a step using the new `o_BallX`:
  - If `o_XDir`=1 and `o_BallX`==H_VISIBLE-BALL_SIZE+1: set `o_XDir`=0 and pulse `o_Bounce`.
  - If `o_XDir`=0 and `o_BallX`==1: set `o_XDir`=1 and pulse `o_Bounce`.
- Because a bounce flips the direction at the limit, `o_BallX` never leaves 1..H_VISIBLE-BALL_SIZE+1 and no wrap-around is possible.
- Vertical bounce stays inside the renderer. Gating `o_VReset` freezes both axes together.
- Simultaneous events:
  - Pause edge together with `i_VReset` in RUN: the pause wins, no step is forwarded and the divider does not advance.
  - Start edge together with `i_VReset` in IDLE: SERVE is entered and that pulse is not counted.

## Timing

- Reset values: state=IDLE, `o_VReset`=0, `o_XDir`=1, `o_BallX`=START_X, `o_Running`=0, `o_Bounce`=0, divider=0, serve counter=0.
- Reset asserted mid-operation returns everything to these values immediately. The renderer is reset by the same net and returns to START_X in step.
- `o_VReset` is registered. It rises exactly 1 cycle after the qualifying `i_VReset` and is held for 1 cycle, which is still inside vertical blanking.
- `o_XDir` changes only on the cycle after a step. It is therefore stable for at least one frame before, and during, every `o_VReset` high cycle.
- `o_Bounce` rises 2 cycles after the qualifying `i_VReset`.
- `o_Running` is registered from the state and reflects RUN from the cycle after entry.

## Test plan

- Reset with `i_VReset` pulsing every 800 cycles: `o_VReset` stays 0. `o_BallX`=316, `o_XDir`=1, all other outputs 0.
- Start edge with SERVE_FRAMES=3: no `o_VReset` for 3 frames. `o_Running`=1 after the 3rd pulse. The 4th `i_VReset` yields `o_VReset` one cycle later and `o_BallX`=317.
- FRAME_DIV=3 in RUN over 9 frames: exactly 3 `o_VReset` pulses, on frames 3, 6 and 9. `o_BallX` advances by 3.
- Run to the right edge: at `o_BallX`=631, `o_Bounce` pulses and `o_XDir`=0. The next step gives 630. Run on to the left edge: at 1, `o_XDir` returns to 1 with one `o_Bounce`.
- Pause edge coincident with `i_VReset`: no step, divider unchanged. The second pause edge resumes and the pulse cadence continues from the held divider.
- `i_Rst_n` low for 1 cycle mid-RUN at `o_BallX`=500, `o_XDir`=0: all outputs return to reset values asynchronously and the state is IDLE.

Source files
------------

// File: rtl/ball_motion_ctrl_if.sv
// Bundle of the frame-pulse, control and ball-state signals that run between
// the VGA timing and control side (master) and ball_motion_ctrl (slave).
//   i_VReset  : one-cycle frame-start pulse from VGA timing
//   i_Start   : debounced start level
//   i_Pause   : debounced pause level
//   o_VReset  : gated frame pulse to the renderer
//   o_XDir    : horizontal direction, 1 = right
//   o_BallX   : tracked left-edge column (1-based)
//   o_Running : high while running
//   o_Bounce  : one-cycle pulse on a direction flip
interface ball_motion_ctrl_if;
  logic       i_VReset;
  logic       i_Start;
  logic       i_Pause;
  logic       o_VReset;
  logic       o_XDir;
  logic [9:0] o_BallX;
  logic       o_Running;
  logic       o_Bounce;

  modport master (
    output i_VReset, i_Start, i_Pause,
    input  o_VReset, o_XDir, o_BallX, o_Running, o_Bounce
  );

  modport slave (
    input  i_VReset, i_Start, i_Pause,
    output o_VReset, o_XDir, o_BallX, o_Running, o_Bounce
  );
endinterface

// File: rtl/ball_motion_ctrl.sv
// Frame-rate motion controller for the bouncing-ball datapath.
// Gates the per-frame vertical-reset pulse to the renderer (one pixel step per
// axis per forwarded pulse), sequences IDLE/SERVE/RUN/PAUSED, and tracks the
// ball's horizontal position so it bounces off the left and right edges.
// Ports:
//   i_Clk   : pixel clock
//   i_Rst_n : asynchronous active-low reset
//   bus     : ball_motion_ctrl_if.slave (frame pulse, start/pause in;
//             gated pulse, direction, column, running, bounce out)
module ball_motion_ctrl #(
  parameter int H_VISIBLE    = 640,
  parameter int BALL_SIZE    = 10,
  parameter int START_X      = 316,
  parameter int FRAME_DIV    = 1,
  parameter int SERVE_FRAMES = 60
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  ball_motion_ctrl_if.slave  bus
);

  localparam logic [9:0] X_MAX      = 10'(H_VISIBLE - BALL_SIZE + 1);
  localparam logic [9:0] X_MIN      = 10'd1;
  localparam logic [9:0] X_START    = 10'(START_X);
  localparam logic [3:0] DIV_LAST   = 4'(FRAME_DIV - 1);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE  = 2'd1,
    RUN    = 2'd2,
    PAUSED = 2'd3
  } state_t;

  state_t     state;
  logic       start_q;
  logic       pause_q;
  logic [7:0] serve_cnt;
  logic [3:0] div;
  logic       start_edge;
  logic       pause_edge;

  // Edge registers reset to 1 so a level held through reset is not an edge.
  assign start_edge = bus.i_Start & ~start_q;
  assign pause_edge = bus.i_Pause & ~pause_q;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state         <= IDLE;
      start_q       <= 1'b1;
      pause_q       <= 1'b1;
      serve_cnt     <= 8'd0;
      div           <= 4'd0;
      bus.o_VReset  <= 1'b0;
      bus.o_XDir    <= 1'b1;
      bus.o_BallX   <= X_START;
      bus.o_Running <= 1'b0;
      bus.o_Bounce  <= 1'b0;
    end else begin
      start_q      <= bus.i_Start;
      pause_q      <= bus.i_Pause;
      bus.o_VReset <= 1'b0;
      bus.o_Bounce <= 1'b0;

      // o_VReset high means o_BallX was just stepped: check the new column
      // against the edge in the direction of travel and flip there.
      if (bus.o_VReset) begin
        if (bus.o_XDir && bus.o_BallX == X_MAX) begin
          bus.o_XDir   <= 1'b0;
          bus.o_Bounce <= 1'b1;
        end else if (!bus.o_XDir && bus.o_BallX == X_MIN) begin
          bus.o_XDir   <= 1'b1;
          bus.o_Bounce <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          // A frame pulse coinciding with the start edge is not counted.
          if (start_edge) begin
            serve_cnt <= 8'd0;
            state     <= SERVE;
          end
        end
        SERVE: begin
          // Count compared before increment: SERVE lasts SERVE_FRAMES pulses.
          if (bus.i_VReset) begin
            serve_cnt <= serve_cnt + 8'd1;
            if (serve_cnt == SERVE_LAST) begin
              state         <= RUN;
              div           <= 4'd0;
              bus.o_Running <= 1'b1;
            end
          end
        end
        RUN: begin
          // Pause takes priority over a coincident frame pulse.
          if (pause_edge) begin
            state         <= PAUSED;
            bus.o_Running <= 1'b0;
          end else if (bus.i_VReset) begin
            if (div == DIV_LAST) begin
              div          <= 4'd0;
              bus.o_VReset <= 1'b1;
              bus.o_BallX  <= bus.o_XDir ? (bus.o_BallX + 10'd1)
                                         : (bus.o_BallX - 10'd1);
            end else begin
              div <= div + 4'd1;
            end
          end
        end
        PAUSED: begin
          // Divider holds here so cadence resumes where it left off.
          if (pause_edge) begin
            state         <= RUN;
            bus.o_Running <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
module tb_ball_motion_ctrl;

  logic clk;
  logic rst_n;

  int n_vec;
  int n_err;

  logic       step_a, step_b;
  logic       bnc_a, bnc_b;
  logic [8:0] seen;
  int         nb, ns;

  ball_motion_ctrl_if ifa ();
  ball_motion_ctrl_if ifb ();

  ball_motion_ctrl #(
    .H_VISIBLE(640), .BALL_SIZE(10), .START_X(316),
    .FRAME_DIV(1), .SERVE_FRAMES(3)
  ) dut_a (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (ifa.slave)
  );

  ball_motion_ctrl #(
    .H_VISIBLE(640), .BALL_SIZE(10), .START_X(316),
    .FRAME_DIV(3), .SERVE_FRAMES(3)
  ) dut_b (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected $finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame pulse on the selected DUT(s); optional pause edge on B in the
  // same cycle. Captures o_VReset one cycle and o_Bounce two cycles after.
  task automatic frame(input bit a, input bit b, input bit pz);
    @(posedge clk); #1;
    if (a)  ifa.i_VReset = 1'b1;
    if (b)  ifb.i_VReset = 1'b1;
    if (pz) ifb.i_Pause  = 1'b1;
    @(posedge clk); #1;
    ifa.i_VReset = 1'b0;
    ifb.i_VReset = 1'b0;
    step_a = ifa.o_VReset;
    step_b = ifb.o_VReset;
    @(posedge clk); #1;
    bnc_a = ifa.o_Bounce;
    bnc_b = ifb.o_Bounce;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    ifa.i_VReset = 1'b0; ifa.i_Start = 1'b0; ifa.i_Pause = 1'b0;
    ifb.i_VReset = 1'b0; ifb.i_Start = 1'b0; ifb.i_Pause = 1'b0;

    // Held in reset with frame pulses arriving
    frame(1, 1, 0);
    chk("rst_vres_a1", step_a, 0);
    chk("rst_vres_b1", step_b, 0);
    repeat (800) @(posedge clk);
    frame(1, 1, 0);
    chk("rst_vres_a2", step_a, 0);
    chk("rst_ballx_a", ifa.o_BallX, 316);
    chk("rst_xdir_a", ifa.o_XDir, 1);
    chk("rst_run_a", ifa.o_Running, 0);
    chk("rst_bounce_a", ifa.o_Bounce, 0);
    chk("rst_ballx_b", ifb.o_BallX, 316);

    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Start edge, then SERVE_FRAMES=3 frames with nothing forwarded
    ifa.i_Start = 1'b1;
    ifb.i_Start = 1'b1;
    tick(3);
    for (int i = 0; i < 3; i++) begin
      frame(1, 1, 0);
      chk("serve_vres_a", step_a, 0);
      chk("serve_vres_b", step_b, 0);
      if (i < 2) chk("serve_run_a", ifa.o_Running, 0);
    end
    tick(1);
    chk("run_after_serve_a", ifa.o_Running, 1);
    chk("run_after_serve_b", ifb.o_Running, 1);

    // First RUN frame with FRAME_DIV=1 steps immediately
    frame(1, 0, 0);
    chk("first_step_a", step_a, 1);
    chk("first_ballx_a", ifa.o_BallX, 317);
    chk("vres_one_cycle_a", ifa.o_VReset, 0);

    // FRAME_DIV=3 over 9 frames: steps on frames 3, 6, 9
    for (int i = 0; i < 9; i++) begin
      frame(0, 1, 0);
      seen[i] = step_b;
    end
    chk("div3_pattern_b", seen, 9'b100100100);
    chk("div3_ballx_b", ifb.o_BallX, 319);

    // Pause coincident with frame pulse; divider held at 1 through pause
    frame(0, 1, 0);
    chk("pre_pause_vres_b", step_b, 0);
    frame(0, 1, 1);
    chk("pause_coinc_vres_b", step_b, 0);
    chk("paused_run_b", ifb.o_Running, 0);
    frame(0, 1, 0);
    chk("paused_vres_b1", step_b, 0);
    frame(0, 1, 0);
    chk("paused_vres_b2", step_b, 0);
    ifb.i_Start = 1'b0;
    tick(1);
    ifb.i_Start = 1'b1;
    tick(2);
    chk("paused_start_ignored_b", ifb.o_Running, 0);
    ifb.i_Pause = 1'b0;
    tick(2);
    ifb.i_Pause = 1'b1;
    tick(2);
    chk("resume_run_b", ifb.o_Running, 1);
    frame(0, 1, 0);
    chk("resume_f1_vres_b", step_b, 0);
    frame(0, 1, 0);
    chk("resume_f2_vres_b", step_b, 1);
    chk("resume_ballx_b", ifb.o_BallX, 320);

    // Right edge: 317 -> 630 without bounce, then 631 bounces
    nb = 0; ns = 0;
    for (int i = 0; i < 313; i++) begin
      frame(1, 0, 0);
      if (bnc_a) nb++;
      if (step_a) ns++;
    end
    chk("right_leg_steps_a", ns, 313);
    chk("right_leg_bounces_a", nb, 0);
    chk("pre_edge_ballx_a", ifa.o_BallX, 630);
    chk("pre_edge_xdir_a", ifa.o_XDir, 1);
    frame(1, 0, 0);
    chk("edge_ballx_a", ifa.o_BallX, 631);
    chk("edge_bounce_a", bnc_a, 1);
    chk("edge_xdir_a", ifa.o_XDir, 0);
    tick(1);
    chk("edge_bounce_done_a", ifa.o_Bounce, 0);
    frame(1, 0, 0);
    chk("after_edge_ballx_a", ifa.o_BallX, 630);
    chk("after_edge_bounce_a", bnc_a, 0);

    // Left edge: 630 -> 2, then 1 bounces back to rightward
    nb = 0;
    for (int i = 0; i < 628; i++) begin
      frame(1, 0, 0);
      if (bnc_a) nb++;
    end
    chk("left_leg_bounces_a", nb, 0);
    chk("pre_left_ballx_a", ifa.o_BallX, 2);
    frame(1, 0, 0);
    chk("left_ballx_a", ifa.o_BallX, 1);
    chk("left_bounce_a", bnc_a, 1);
    chk("left_xdir_a", ifa.o_XDir, 1);
    frame(1, 0, 0);
    chk("after_left_ballx_a", ifa.o_BallX, 2);

    // Out to 631 and back to 500 heading left
    nb = 0;
    for (int i = 0; i < 760; i++) begin
      frame(1, 0, 0);
      if (bnc_a) nb++;
    end
    chk("return_bounces_a", nb, 1);
    chk("return_ballx_a", ifa.o_BallX, 500);
    chk("return_xdir_a", ifa.o_XDir, 0);

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_ballx_a", ifa.o_BallX, 316);
    chk("async_xdir_a", ifa.o_XDir, 1);
    chk("async_run_a", ifa.o_Running, 0);
    chk("async_vres_a", ifa.o_VReset, 0);
    chk("async_bounce_a", ifa.o_Bounce, 0);
    chk("async_run_b", ifb.o_Running, 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Back in IDLE: start level held through reset is not an edge
    ns = 0;
    for (int i = 0; i < 5; i++) begin
      frame(1, 0, 0);
      if (step_a) ns++;
    end
    chk("idle_after_rst_steps_a", ns, 0);
    chk("idle_after_rst_run_a", ifa.o_Running, 0);
    chk("idle_after_rst_ballx_a", ifa.o_BallX, 316);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
